spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
Transaction controller behind the SPI slave byte shifter on the clk50m domain. It parses the first byte of each CS-low frame as a command: bit7 = write, bits6:0 = start address. Subsequent bytes become register writes, or prefetched register reads returned on MISO, with the address auto-incrementing. It drives a simple register bus and a one-byte TX holding register for the shifter.

Parameters:
ADDR_W, 7, register address width (command bits ADDR_W-1:0)
TIMEOUT, 16, clk50m cycles to wait for reg_rd_ack before a read is abandoned
ERR_BYTE, 8'hFF, TX byte loaded on read timeout

Ports:
clk50m  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-high (asserted = 1)
cs_act  in  1  synchronized chip-select active level (1 = frame open)
rx_valid  in  1  one-cycle pulse, complete byte received from shifter
rx_data  in  8  received byte, valid with rx_valid
tx_data  out  8  byte the shifter loads for the next MISO byte
tx_valid  out  1  tx_data holds fresh read data
reg_wr_en  out  1  one-cycle register write strobe
reg_rd_en  out  1  one-cycle register read request
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  write data
reg_rd_ack  in  1  one-cycle pulse, reg_rdata valid
reg_rdata  in  8  read data
busy  out  1  frame in progress (state != IDLE)
err_timeout  out  1  sticky, read ack timed out; cleared at next frame start
err_underrun  out  1  sticky, byte clocked while read pending; cleared at next frame start
byte_cnt  out  8  bytes received in current frame, saturates at 255

Behaviour:
- Reset: all outputs 0, tx_data = 8'h00, state IDLE, timeout counter 0.
- States:
  - IDLE: cs_act 0->1 -> CMD; clear err flags and byte_cnt.
  - CMD: rx_valid -> latch addr = rx_data[ADDR_W-1:0]. bit7 = 1 -> WR. bit7 = 0 -> RD_REQ.
  - WR: each rx_valid at cycle t -> reg_wr_en = 1, reg_wdata = rx_data, reg_addr = current addr at t+1. addr increments after the strobe.
  - RD_REQ: reg_rd_en pulses for one cycle with reg_addr, then -> RD_WAIT.
  - RD_WAIT: reg_rd_ack -> tx_data = reg_rdata, tx_valid = 1 on the next cycle, addr++, -> RD_DATA. No ack within TIMEOUT cycles -> tx_data = ERR_BYTE, tx_valid = 1, err_timeout = 1, addr++, -> RD_DATA.
  - RD_DATA: rx_valid (dummy byte; byte consumed by master) -> tx_valid = 0, -> RD_REQ (prefetch next address).
  - rx_valid in RD_REQ/RD_WAIT -> err_underrun = 1, byte counted, state unchanged.
- Latency: command byte rx_valid at t -> reg_rd_en at t+1. Ack at a -> tx_valid at a+1.
- Address wrap: addr increments modulo 2^ADDR_W (7F -> 00).
- byte_cnt increments on every rx_valid while busy, including the command byte.
- cs_act falling in any state: -> IDLE next cycle. busy = 0, tx_valid = 0, tx_data = 8'h00.
  - A pending read is dropped; a late reg_rd_ack is ignored.
  - rx_valid in the same cycle as the cs_act fall is discarded: no strobe, not counted.
  - Err flags and byte_cnt hold until the next frame start.
- reg_wr_en and reg_rd_en never assert in the same cycle; each lasts exactly one cycle.
- Reset asserted mid-frame: immediate return to reset values; no strobe emitted.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE, CMD, WR, RD_REQ, RD_WAIT, RD_DATA)
  - CMD_WR_BIT = 7
  - ERR_BYTE default
- One sub-module, spi_rd_timer: loadable down-counter producing the timeout pulse.
- The FSM, address counter and TX holding register stay in spi_reg_ctrl.

Test Plan:
- Write frame: cs_act = 1, bytes 0xB5, 0x10, cs_act = 0 -> one reg_wr_en with reg_addr = 0x35, reg_wdata = 0x10; byte_cnt = 2; busy back to 0.
- Burst write with wrap: cmd 0xFF, data 0xAA, 0xBB -> writes 0xAA @ 0x7F, then 0xBB @ 0x00.
- Read with prefetch: cmd 0x12, ack after 3 cycles with 0x5C, dummy byte, ack 0x6D -> reg_rd_en @ 0x12 then 0x13; tx_data 0x5C then 0x6D; tx_valid a+1 after each ack.
- Timeout: cmd 0x20, no ack -> after 16 cycles tx_data = 0xFF, err_timeout = 1; next frame start clears it.
- Abort mid-read: cmd 0x20, cs_act falls before ack, ack arrives later -> no tx_valid; state IDLE; tx_data = 0x00.
- Async reset during WR after 0xB5 -> outputs at reset values immediately; no reg_wr_en emitted.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI register-access controller: the transaction
// FSM state encoding, the command-byte write flag position and the default
// byte returned to the master when a register read times out.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR      = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        RD_DATA = 3'd5
    } state_t;

    // Bit of the command byte that selects write (1) or read (0).
    localparam int CMD_WR_BIT = 7;

    // Byte shifted out on MISO when a register read is abandoned.
    localparam logic [7:0] ERR_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/spi_rd_timer.sv
// -----------------------------------------------------------------------------
// spi_rd_timer
// Loadable down-counter that bounds how long a register read may wait for its
// acknowledge. Loaded while the read request is issued, it counts down while
// the controller waits and flags expiry on the last permitted wait cycle, so
// exactly TIMEOUT wait cycles are available for the acknowledge.
//
// Ports:
//   clk50m  in   system clock
//   rst_n   in   asynchronous reset, active-high (legacy name)
//   load    in   reload the counter with TIMEOUT
//   en      in   count down (controller is waiting for an ack)
//   expire  out  last wait cycle reached without an ack
// -----------------------------------------------------------------------------
module spi_rd_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk50m,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk50m or posedge rst_n) begin
        if (rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT);
        end else if (en && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expire = en && (count == CW'(1));

endmodule

// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
// Transaction controller behind the SPI slave byte shifter. The first byte of
// every chip-select frame is a command (bit7 = write, low bits = start
// address); following bytes are either written to the register bus or act as
// dummy bytes while prefetched read data is offered on MISO. The address
// auto-increments and wraps modulo 2^ADDR_W.
//
// Ports:
//   clk50m       in   system clock, 50 MHz
//   rst_n        in   asynchronous reset, active-high despite the legacy name
//   cs_act       in   synchronized chip-select, 1 = frame open
//   rx_valid     in   one-cycle pulse, rx_data holds a complete byte
//   rx_data      in   received byte
//   tx_data      out  byte the shifter loads for the next MISO byte
//   tx_valid     out  tx_data holds fresh read data
//   reg_wr_en    out  one-cycle register write strobe
//   reg_rd_en    out  one-cycle register read request
//   reg_addr     out  register address
//   reg_wdata    out  register write data
//   reg_rd_ack   in   one-cycle pulse, reg_rdata valid
//   reg_rdata    in   register read data
//   busy         out  frame in progress
//   err_timeout  out  sticky: a read ack timed out (cleared at frame start)
//   err_underrun out  sticky: byte arrived while a read was pending
//   byte_cnt     out  bytes received in this frame, saturating at 255
// -----------------------------------------------------------------------------
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int         ADDR_W   = 7,
    parameter int         TIMEOUT  = 16,
    parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
) (
    input  logic              clk50m,
    input  logic              rst_n,
    input  logic              cs_act,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic              reg_rd_ack,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_underrun,
    output logic [7:0]        byte_cnt
);

    state_t            state;
    logic              cs_d;
    logic [ADDR_W-1:0] addr;
    logic              rd_expire;

    spi_rd_timer #(.TIMEOUT(TIMEOUT)) u_rd_timer (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .load   (state == RD_REQ),
        .en     (state == RD_WAIT),
        .expire (rd_expire)
    );

    // The read request is decoded from state: RD_REQ always lasts exactly one
    // cycle, so the strobe is one cycle wide and can never overlap reg_wr_en,
    // which only fires in WR.
    assign reg_rd_en = (state == RD_REQ);
    assign reg_addr  = addr;
    assign busy      = (state != IDLE);

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch sees the pre-edge values (e.g. the addr increment keyed off the
    // previous cycle's reg_wr_en).
    always_ff @(posedge clk50m or posedge rst_n) begin
        if (rst_n) begin
            state        <= IDLE;
            cs_d         <= 1'b0;
            addr         <= '0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            reg_wr_en    <= 1'b0;
            reg_wdata    <= 8'h00;
            err_timeout  <= 1'b0;
            err_underrun <= 1'b0;
            byte_cnt     <= 8'h00;
        end else begin
            cs_d      <= cs_act;
            reg_wr_en <= 1'b0;

            if (state != IDLE && !cs_act) begin
                // Frame closed: drop any pending read and discard a byte
                // landing in this cycle. Error flags and byte_cnt hold.
                state    <= IDLE;
                tx_valid <= 1'b0;
                tx_data  <= 8'h00;
            end else begin
                if (state != IDLE && rx_valid && byte_cnt != 8'hFF) begin
                    byte_cnt <= byte_cnt + 8'd1;
                end

                case (state)
                    IDLE: begin
                        if (cs_act && !cs_d) begin
                            state        <= CMD;
                            err_timeout  <= 1'b0;
                            err_underrun <= 1'b0;
                            byte_cnt     <= 8'h00;
                        end
                    end

                    CMD: begin
                        if (rx_valid) begin
                            addr  <= rx_data[ADDR_W-1:0];
                            state <= rx_data[CMD_WR_BIT] ? WR : RD_REQ;
                        end
                    end

                    WR: begin
                        if (rx_valid) begin
                            reg_wr_en <= 1'b1;
                            reg_wdata <= rx_data;
                        end
                        // Advance only once the strobe has presented the
                        // current address on the bus.
                        if (reg_wr_en) begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end

                    RD_REQ: begin
                        state <= RD_WAIT;
                        if (rx_valid) begin
                            err_underrun <= 1'b1;
                        end
                    end

                    RD_WAIT: begin
                        if (rx_valid) begin
                            err_underrun <= 1'b1;
                        end
                        if (reg_rd_ack) begin
                            tx_data  <= reg_rdata;
                            tx_valid <= 1'b1;
                            addr     <= addr + ADDR_W'(1);
                            state    <= RD_DATA;
                        end else if (rd_expire) begin
                            tx_data     <= ERR_BYTE;
                            tx_valid    <= 1'b1;
                            err_timeout <= 1'b1;
                            addr        <= addr + ADDR_W'(1);
                            state       <= RD_DATA;
                        end
                    end

                    RD_DATA: begin
                        // The master has clocked out the prefetched byte;
                        // start fetching the next address.
                        if (rx_valid) begin
                            tx_valid <= 1'b0;
                            state    <= RD_REQ;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_ctrl
// Directed self-checking bench for spi_reg_ctrl. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spi_reg_ctrl;

    logic       clk50m;
    logic       rst_n;
    logic       cs_act;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_rd_ack;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err_timeout;
    logic       err_underrun;
    logic [7:0] byte_cnt;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;

    spi_reg_ctrl dut (
        .clk50m       (clk50m),
        .rst_n        (rst_n),
        .cs_act       (cs_act),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .reg_wr_en    (reg_wr_en),
        .reg_rd_en    (reg_rd_en),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rd_ack   (reg_rd_ack),
        .reg_rdata    (reg_rdata),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_underrun (err_underrun),
        .byte_cnt     (byte_cnt)
    );

    initial clk50m = 1'b0;
    always #5 clk50m = ~clk50m;

    // Strobe monitor: cumulative counts, compared as deltas by the tests.
    always @(posedge clk50m) begin
        if (reg_wr_en) wr_cnt <= wr_cnt + 1;
        if (reg_rd_en) rd_cnt <= rd_cnt + 1;
        if (reg_wr_en && reg_rd_en) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk50m);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        reg_rd_ack = 1'b1;
        reg_rdata  = d;
        tick();
        reg_rd_ack = 1'b0;
    endtask

    task automatic frame_start();
        cs_act = 1'b1;
        tick();
    endtask

    task automatic frame_end();
        cs_act = 1'b0;
        tick();
        tick();
    endtask

    int wr_base;
    int rd_base;
    int n;

    initial begin
        rst_n      = 1'b1;
        cs_act     = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        reg_rd_ack = 1'b0;
        reg_rdata  = 8'h00;
        tick();
        tick();

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_strobes", {reg_wr_en, reg_rd_en}, 2'b00);
        check("rst_byte_cnt", byte_cnt, 8'h00);
        rst_n = 1'b0;
        tick();

        // Single write: 0xB5 -> write @0x35, data 0x10
        wr_base = wr_cnt;
        frame_start();
        check("wr_busy", busy, 1'b1);
        send_byte(8'hB5);
        send_byte(8'h10);
        check("wr_strobe", reg_wr_en, 1'b1);
        check("wr_addr", reg_addr, 7'h35);
        check("wr_data", reg_wdata, 8'h10);
        check("wr_no_rd", reg_rd_en, 1'b0);
        tick();
        check("wr_strobe_1cyc", reg_wr_en, 1'b0);
        frame_end();
        check("wr_count", wr_cnt - wr_base, 1);
        check("wr_byte_cnt", byte_cnt, 8'd2);
        check("wr_busy_end", busy, 1'b0);

        // Burst write with address wrap 0x7F -> 0x00
        wr_base = wr_cnt;
        frame_start();
        send_byte(8'hFF);
        send_byte(8'hAA);
        check("wrap_addr0", reg_addr, 7'h7F);
        check("wrap_data0", reg_wdata, 8'hAA);
        send_byte(8'hBB);
        check("wrap_strobe1", reg_wr_en, 1'b1);
        check("wrap_addr1", reg_addr, 7'h00);
        check("wrap_data1", reg_wdata, 8'hBB);
        frame_end();
        check("wrap_count", wr_cnt - wr_base, 2);
        check("wrap_byte_cnt", byte_cnt, 8'd3);

        // Read with prefetch
        rd_base = rd_cnt;
        frame_start();
        send_byte(8'h12);
        check("rd_req0", reg_rd_en, 1'b1);
        check("rd_addr0", reg_addr, 7'h12);
        tick();
        check("rd_req0_1cyc", reg_rd_en, 1'b0);
        tick();
        tick();
        check("rd_wait_txv", tx_valid, 1'b0);
        ack(8'h5C);
        check("rd_txv0", tx_valid, 1'b1);
        check("rd_txd0", tx_data, 8'h5C);
        send_byte(8'h00);
        check("rd_txv_clr", tx_valid, 1'b0);
        check("rd_req1", reg_rd_en, 1'b1);
        check("rd_addr1", reg_addr, 7'h13);
        tick();
        ack(8'h6D);
        check("rd_txv1", tx_valid, 1'b1);
        check("rd_txd1", tx_data, 8'h6D);
        check("rd_count", rd_cnt - rd_base, 2);
        check("rd_byte_cnt", byte_cnt, 8'd2);
        check("rd_underrun", err_underrun, 1'b0);
        frame_end();
        check("rd_end_txv", tx_valid, 1'b0);
        check("rd_end_txd", tx_data, 8'h00);

        // Timeout: cmd edge, then tx_valid appears 17 edges later
        frame_start();
        send_byte(8'h20);
        n = 0;
        while (!tx_valid && n < 40) begin
            tick();
            n++;
        end
        check("to_latency", n, 17);
        check("to_txd", tx_data, 8'hFF);
        check("to_err", err_timeout, 1'b1);
        check("to_addr_inc", reg_addr, 7'h21);
        frame_end();
        check("to_err_hold", err_timeout, 1'b1);

        // Next frame start clears flags; byte during pending read -> underrun
        frame_start();
        check("to_err_clr", err_timeout, 1'b0);
        check("frame_cnt_clr", byte_cnt, 8'd0);
        send_byte(8'h40);
        tick();
        send_byte(8'h99);
        check("ur_flag", err_underrun, 1'b1);
        check("ur_byte_cnt", byte_cnt, 8'd2);
        check("ur_busy", busy, 1'b1);
        frame_end();
        check("ur_hold", err_underrun, 1'b1);

        // Abort mid-read; byte coinciding with cs fall is discarded
        frame_start();
        check("ur_clr", err_underrun, 1'b0);
        send_byte(8'h20);
        tick();
        cs_act   = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick();
        rx_valid = 1'b0;
        check("ab_busy", busy, 1'b0);
        ack(8'h77);
        tick();
        check("ab_txv", tx_valid, 1'b0);
        check("ab_txd", tx_data, 8'h00);
        check("ab_byte_cnt", byte_cnt, 8'd1);
        check("ab_busy2", busy, 1'b0);
        tick();

        // Async reset during a write frame
        wr_base = wr_cnt;
        frame_start();
        send_byte(8'hB5);
        rx_valid = 1'b1;
        rx_data  = 8'h10;
        #1 rst_n = 1'b1;
        #1;
        check("ar_busy", busy, 1'b0);
        check("ar_wr_en", reg_wr_en, 1'b0);
        check("ar_byte_cnt", byte_cnt, 8'd0);
        check("ar_addr", reg_addr, 7'h00);
        tick();
        rx_valid = 1'b0;
        cs_act   = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        check("ar_no_strobe", wr_cnt - wr_base, 0);
        check("ar_idle", busy, 1'b0);
        check("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
